dm_trace_buffer: RTL
====================

# dm_trace_buffer

Synthesizable, parametrised data-memory access tracer that sits beside the CPU core's data-memory port. It qualifies each store (and optionally load) by address window, and captures PC, address, data and direction into a DEPTH-entry first-word-fall-through FIFO. The FIFO is drained over a valid/ready interface. It also keeps saturating event and drop statistics. It replaces ad-hoc simulation-only store printing with a hardware trace usable in both simulation and FPGA builds.

## Interface

Parameters:
- PC_W, 32, width of captured PC
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data width
- DEPTH, 8, FIFO entries; power of two, at least 2
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous and active-high
- en  in  1  capture enable
- cap_reads  in  1  1 = also capture loads
- mode_wrap  in  1  0 = drop new event when full; 1 = overwrite oldest entry
- lo_addr, hi_addr  in  ADDR_W  inclusive unsigned address window
- clr_stats  in  1  synchronous clear of statistics
- dm_we, dm_re  in  1  data-memory write/read strobes
- dm_addr  in  ADDR_W  data-memory address
- dm_data  in  DATA_W  store data (write) or load data (read)
- id_pc  in  PC_W  PC of the accessing instruction
- tr_valid  out  1  FIFO head valid
- tr_ready  in  1  consumer accepts head
- tr_pc, tr_addr, tr_data  out  PC_W/ADDR_W/DATA_W  head entry fields
- tr_wr  out  1  head entry is a write (1) or read (0)
- level  out  clog2(DEPTH)+1  entries held, 0..DEPTH
- evt_cnt, drop_cnt  out  CNT_W  qualified events / dropped or overwritten events
- overflow, conflict  out  1  sticky flags

## Operation

- Write event: dm_we=1, dm_re=0. Read event: dm_re=1, dm_we=0, cap_reads=1.
- dm_we=1 and dm_re=1 together: no capture; set conflict.
- An event is qualified when en=1 and lo_addr <= dm_addr <= hi_addr (unsigned).
- If lo_addr > hi_addr, nothing qualifies.
- Each qualified event increments evt_cnt (saturating at all-ones) and requests a push of {id_pc, dm_addr, dm_data, dm_we}.
- Pop = tr_valid and tr_ready. tr_valid = (level != 0). Head fields are read combinationally from the rd pointer and are don't-care when tr_valid=0.
- Push while not full: write at wr_ptr and advance it. level +1, or unchanged if a pop occurs in the same cycle.
- Push while full with a pop in the same cycle: accepted, no drop, level stays DEPTH.
- Push while full without a pop, mode_wrap=0: event discarded; drop_cnt +1 (saturating); overflow=1.
- Push while full without a pop, mode_wrap=1: overwrite the oldest entry and advance both pointers; level stays DEPTH; drop_cnt +1; overflow=1. The head changes while tr_valid=1, which is the accepted exception to valid/ready stability in wrap mode.
- Pop while empty cannot occur, because tr_valid=0.
- Pointers wrap modulo DEPTH.
- clr_stats=1 zeroes evt_cnt, drop_cnt, overflow and conflict on the next edge. Clear wins over a same-cycle increment or set. FIFO contents are untouched.
- en=0 does not block draining.

## Timing

- Reset (async, immediate): pointers=0, level=0, tr_valid=0, evt_cnt=0, drop_cnt=0, overflow=0, conflict=0. Head data outputs read don't-care.
- Capture is sampled at the rising edge. An entry pushed at edge N gives tr_valid=1 after edge N, so it is poppable at edge N+1. Latency is one cycle.
- Throughput: one push and one pop per cycle, sustained.
- level, evt_cnt, drop_cnt and the flags update at the same edge as the push or pop that changes them.
- Reset asserted mid-operation discards all entries and statistics. There is no partial state after deassertion.

## Test plan

- Reset, then 3 writes (pc=4/8/12, addr=0x10/0x14/0x18, data=1/2/3), window 0..0xFFFF, tr_ready=0 → level=3, evt_cnt=3. Then tr_ready=1 → heads in order pc 4, 8, 12 with tr_wr=1, then tr_valid=0.
- DEPTH=8, mode_wrap=0, 10 writes data 0..9, no drain → level=8, drop_cnt=2, overflow=1. Drain yields data 0..7.
- Same stimulus with mode_wrap=1 → level=8, drop_cnt=2. Drain yields data 2..9.
- Window lo=0x100, hi=0x1FF; writes to 0xFF, 0x100, 0x1FF, 0x200 → exactly 0x100 and 0x1FF captured, evt_cnt=2. cap_reads=0 read to 0x150 → not captured; cap_reads=1 → captured with tr_wr=0.
- Full FIFO with simultaneous push and pop each cycle for 20 cycles → level stays 8, drop_cnt=0. dm_we=dm_re=1 → conflict=1, level unchanged. clr_stats with a concurrent qualified event → evt_cnt=0, conflict=0 next cycle.
- rst pulsed asynchronously between edges with level=5 → tr_valid=0, level=0, all counters 0 before the next edge.

Source files
------------

// File: rtl/dm_trace_buffer.sv
// Data-memory access tracer: window-qualified load/store capture into a
// first-word-fall-through FIFO with saturating event/drop statistics.
module dm_trace_buffer #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cap_reads,
    input  logic                       mode_wrap,
    input  logic [ADDR_W-1:0]          lo_addr,
    input  logic [ADDR_W-1:0]          hi_addr,
    input  logic                       clr_stats,
    input  logic                       dm_we,
    input  logic                       dm_re,
    input  logic [ADDR_W-1:0]          dm_addr,
    input  logic [DATA_W-1:0]          dm_data,
    input  logic [PC_W-1:0]            id_pc,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [PC_W-1:0]            tr_pc,
    output logic [ADDR_W-1:0]          tr_addr,
    output logic [DATA_W-1:0]          tr_data,
    output logic                       tr_wr,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           evt_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       overflow,
    output logic                       conflict
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              wr_mem   [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;

    logic is_wr, is_rd, in_win, qual, full, pop;
    logic push_ok, overwrite, drop, both;

    always_comb begin
        is_wr     = dm_we & ~dm_re;
        is_rd     = dm_re & ~dm_we & cap_reads;
        both      = dm_we & dm_re;
        // An inverted window (lo > hi) can never satisfy both bounds.
        in_win    = (dm_addr >= lo_addr) && (dm_addr <= hi_addr);
        qual      = en & (is_wr | is_rd) & in_win;
        full      = (level == LW'(DEPTH));
        pop       = tr_valid & tr_ready;
        push_ok   = qual & (~full | pop);
        drop      = qual & full & ~pop;
        overwrite = drop & mode_wrap;
    end

    assign tr_valid = (level != '0);
    assign tr_pc    = pc_mem[rd_ptr];
    assign tr_addr  = addr_mem[rd_ptr];
    assign tr_data  = data_mem[rd_ptr];
    assign tr_wr    = wr_mem[rd_ptr];

    // Storage carries no reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (push_ok | overwrite) begin
            pc_mem[wr_ptr]   <= id_pc;
            addr_mem[wr_ptr] <= dm_addr;
            data_mem[wr_ptr] <= dm_data;
            wr_mem[wr_ptr]   <= dm_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok | overwrite)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop | overwrite)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok & ~pop)
                level <= level + LW'(1);
            else if (pop & ~push_ok)
                level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            conflict <= 1'b0;
        end else if (clr_stats) begin
            evt_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            conflict <= 1'b0;
        end else begin
            if (qual && evt_cnt != '1)
                evt_cnt <= evt_cnt + CNT_W'(1);
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
            if (drop)
                overflow <= 1'b1;
            if (both)
                conflict <= 1'b1;
        end
    end

endmodule
